// File: rtl/systolic_input_feeder.sv
// Per-row operand FIFO bank feeding one edge of the systolic array.
// The host fills one FIFO per row. Each controller `next` pops every selected
// row onto its registered lane. Unselected or empty rows drive zero.
module systolic_input_feeder #(
    parameter int SIZE   = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [$clog2(SIZE)-1:0]  wr_row,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [SIZE-1:0]          memsel,
    input  logic                     next,
    output logic [SIZE*DATA_W-1:0]   data_out,
    output logic [SIZE-1:0]          row_empty,
    output logic [SIZE-1:0]          row_full,
    output logic [SIZE-1:0]          underflow,
    output logic [SIZE-1:0]          overflow
);

    localparam int RW = $clog2(SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem    [SIZE][DEPTH];
    logic [PW-1:0]     rd_ptr [SIZE];
    logic [PW-1:0]     wr_ptr [SIZE];
    logic [CW-1:0]     count  [SIZE];
    logic [DATA_W-1:0] lane   [SIZE];

    logic [SIZE-1:0] pop_ok;
    logic [SIZE-1:0] pop_dry;
    logic [SIZE-1:0] wr_ok;
    logic [SIZE-1:0] wr_drop;

    // Per-row status and accept/reject decisions for this cycle's write and pop.
    // A pop on a full row frees a slot on the same edge, so a simultaneous write is accepted.
    always_comb begin
        row_empty = '0;
        row_full  = '0;
        pop_ok    = '0;
        pop_dry   = '0;
        wr_ok     = '0;
        wr_drop   = '0;
        for (int i = 0; i < SIZE; i++) begin
            row_empty[i] = (count[i] == '0);
            row_full[i]  = (count[i] == FULL_CNT);
            pop_ok[i]    = next && memsel[i] && !row_empty[i];
            pop_dry[i]   = next && memsel[i] && row_empty[i];
            wr_ok[i]     = wr_en && (wr_row == RW'(i)) && (!row_full[i] || pop_ok[i]);
            wr_drop[i]   = wr_en && (wr_row == RW'(i)) && row_full[i] && !pop_ok[i];
        end
    end

    // FIFO storage writes; contents need no reset because pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (!flush && wr_ok[i]) begin
                mem[i][wr_ptr[i]] <= wr_data;
            end
        end
    end

    // Pointers, counts, lane registers and sticky flags; flush behaves like reset but synchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                lane[i]   <= '0;
            end
            underflow <= '0;
            overflow  <= '0;
        end else if (flush) begin
            for (int i = 0; i < SIZE; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                lane[i]   <= '0;
            end
            underflow <= '0;
            overflow  <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop_ok[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({wr_ok[i], pop_ok[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
                if (next) begin
                    lane[i] <= pop_ok[i] ? mem[i][rd_ptr[i]] : '0;
                end
                if (pop_dry[i]) begin
                    underflow[i] <= 1'b1;
                end
                if (wr_drop[i]) begin
                    overflow[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        assign data_out[g*DATA_W +: DATA_W] = lane[g];
    end

endmodule
